// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//   Elastic pipeline-stage register with a valid/ready handshake and a
//   2-entry skid buffer (head + skid). Upstream ready is a flop, so it never
//   depends combinationally on out_ready. Flush empties the stage and drives
//   BUBBLE on the output. Two saturating event counters report stall cycles
//   and flushes that discard live entries.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      discard all held entries this cycle (beats accepted now are lost)
//   in_valid   upstream presents in_data
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a live entry
//   out_ready  downstream accepts
//   out_data   head entry, BUBBLE when out_valid=0
//   stall_cnt  cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_cnt  cycles with flush=1 while the stage holds an entry (saturating)
// ---------------------------------------------------------------------------
// state   | meaning
// EMPTY   | nothing held, out_valid=0, in_ready=1
// ONE     | head valid, skid empty, in_ready=1
// FULL    | head and skid valid, in_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int                 DATA_W = 68,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
    parameter int                 CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic acc;
    logic pop;
    logic stall_evt;
    logic flush_evt;

    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = head_q;
    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any transfer; an accept in this cycle is dropped.
            state_d = S_EMPTY;
            head_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        state_d = S_ONE;
                        head_d  = in_data;
                    end
                end
                S_ONE: begin
                    if (acc && pop) begin
                        head_d = in_data;
                    end else if (acc) begin
                        state_d = S_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                        head_d  = BUBBLE;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    head_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != S_FULL);

    // The skid only holds data when head does, so out_valid covers both.
    assign stall_evt = out_valid & ~out_ready;
    assign flush_evt = flush & out_valid;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            head_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Self-checking bench for pipe_stage_buf. Two instances share all inputs:
//   a default one (CNT_W=16) and one with CNT_W=2 to exercise saturation.
//   A queue-based reference model predicts outputs after every clock edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int DW = 68;
    localparam logic [DW-1:0] BUB = {DW{1'b0}};

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready,  in_ready_s;
    logic          out_valid, out_valid_s;
    logic [DW-1:0] out_data,  out_data_s;
    logic [15:0]   stall_cnt, flush_cnt;
    logic [1:0]    stall_cnt_s, flush_cnt_s;

    pipe_stage_buf #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_stage_buf #(.DATA_W(DW), .CNT_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .stall_cnt (stall_cnt_s),
        .flush_cnt (flush_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 whose ready flag is
    // registered from the post-edge occupancy.
    logic [DW-1:0] mq[$];
    bit            m_rdy;
    int            m_stall;
    int            m_flush;

    function automatic logic [127:0] sat(input int v, input int maxv);
        return (v > maxv) ? 128'(maxv) : 128'(v);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rdy   = 1'b1;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_edge();
        bit do_acc, do_pop;
        do_acc = in_valid && m_rdy;
        do_pop = (mq.size() > 0) && out_ready;
        if ((mq.size() > 0) && !out_ready) m_stall++;
        if (flush && (mq.size() > 0)) m_flush++;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_acc) mq.push_back(in_data);
        end
        m_rdy = (mq.size() < 2);
    endtask

    task automatic compare_all();
        logic [DW-1:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : BUB;
        check_val("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        check_val("in_ready",  128'(in_ready),  128'(m_rdy));
        check_val("out_data",  128'(out_data),  128'(exp_d));
        check_val("stall_cnt", 128'(stall_cnt), sat(m_stall, 65535));
        check_val("flush_cnt", 128'(flush_cnt), sat(m_flush, 65535));
        check_val("s_out_data",  128'(out_data_s),  128'(exp_d));
        check_val("s_in_ready",  128'(in_ready_s),  128'(m_rdy));
        check_val("s_stall_cnt", 128'(stall_cnt_s), sat(m_stall, 3));
        check_val("s_flush_cnt", 128'(flush_cnt_s), sat(m_flush, 3));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        logic [DW-1:0] rd;
        rst = 1'b1;
        drive(0, '0, 0, 0);
        model_reset();
        #12;
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_in_ready",  128'(in_ready),  128'(1));
        check_val("rst_out_data",  128'(out_data),  128'(BUB));
        check_val("rst_stall",     128'(stall_cnt), 128'(0));
        check_val("rst_flush",     128'(flush_cnt), 128'(0));
        rst = 1'b0;

        // Stream 1..8 at full rate; each appears one cycle after its accept.
        for (int k = 1; k <= 8; k++) begin
            drive(1, DW'(k), 1, 0);
            step();
            check_val("stream_data", 128'(out_data), 128'(k));
            check_val("stream_rdy",  128'(in_ready), 128'(1));
        end
        drive(0, '0, 1, 0);
        step();
        check_val("stream_stall", 128'(stall_cnt), 128'(0));
        check_val("stream_drain", 128'(out_valid), 128'(0));

        // Backpressure into the skid, then release: A, B, C in order.
        drive(1, DW'('hA), 0, 0); step();
        drive(1, DW'('hB), 0, 0); step();
        check_val("skid_rdy_low", 128'(in_ready), 128'(0));
        drive(1, DW'('hC), 0, 0); step();
        check_val("skid_hold_A", 128'(out_data), 128'('hA));
        check_val("skid_stall2", 128'(stall_cnt), 128'(2));
        drive(1, DW'('hC), 1, 0); step();
        check_val("order_B", 128'(out_data), 128'('hB));
        step();
        check_val("order_C", 128'(out_data), 128'('hC));
        drive(0, '0, 1, 0); step();
        check_val("order_empty", 128'(out_valid), 128'(0));
        check_val("order_stall", 128'(stall_cnt), 128'(2));

        // Flush while FULL with a concurrent offer of D.
        drive(1, DW'('hA), 0, 0); step();
        drive(1, DW'('hB), 0, 0); step();
        drive(1, DW'('hD), 0, 1); step();
        check_val("flush_valid", 128'(out_valid), 128'(0));
        check_val("flush_data",  128'(out_data),  128'(BUB));
        check_val("flush_rdy",   128'(in_ready),  128'(1));
        check_val("flush_cnt1",  128'(flush_cnt), 128'(1));
        drive(0, '0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("flush_no_D", 128'(out_valid), 128'(0));
        end

        // Saturation of the 2-bit counter: 1,2,3,3,3,3.
        @(negedge clk); rst = 1'b1; #1 model_reset(); @(negedge clk); rst = 1'b0;
        drive(1, DW'('h5), 0, 0); step();
        drive(0, '0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_val("sat_stall", 128'(stall_cnt_s), 128'((k > 3) ? 3 : k));
        end

        // Asynchronous reset between edges while FULL.
        drive(1, DW'('h6), 0, 0); step();
        check_val("pre_rst_full", 128'(in_ready), 128'(0));
        drive(0, '0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", 128'(out_valid), 128'(0));
        check_val("arst_rdy",   128'(in_ready),  128'(1));
        check_val("arst_stall", 128'(stall_cnt), 128'(0));
        check_val("arst_flush", 128'(flush_cnt), 128'(0));
        check_val("arst_s_stall", 128'(stall_cnt_s), 128'(0));
        model_reset();
        #2 rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            rd = {$urandom(), $urandom(), 4'($urandom())};
            drive(($urandom_range(3, 0) != 0), rd, ($urandom_range(1, 0) == 1),
                  ($urandom_range(15, 0) == 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
